// File: rtl/sm_pkg.sv
// Shared types and sign-magnitude ordering helpers for the stream min/max tracker.
package sm_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      HOLD
   } sm_state_t;

   // Helpers work on magnitudes zero-extended to this width.
   localparam int SM_MAXW = 64;
   localparam int SM_MW   = SM_MAXW - 1;

   function automatic int sm_sign_pos(input int w);
      return w - 1;
   endfunction

   function automatic int sm_mag_msb(input int w);
      return w - 2;
   endfunction

   // A zero magnitude is never negative, so -0 and +0 collapse.
   function automatic logic sm_neg(
      input logic             s,
      input logic [SM_MW-1:0] m
   );
      return s && (m != '0);
   endfunction

   function automatic logic sm_gt(
      input logic             sa,
      input logic [SM_MW-1:0] ma,
      input logic             sb,
      input logic [SM_MW-1:0] mb
   );
      logic na;
      logic nb;
      logic r;
      na = sm_neg(sa, ma);
      nb = sm_neg(sb, mb);
      if (na != nb) r = nb;
      else if (na)  r = (ma < mb);
      else          r = (ma > mb);
      return r;
   endfunction

   function automatic logic sm_eq(
      input logic             sa,
      input logic [SM_MW-1:0] ma,
      input logic             sb,
      input logic [SM_MW-1:0] mb
   );
      return (sm_neg(sa, ma) == sm_neg(sb, mb)) && (ma == mb);
   endfunction

endpackage

// File: rtl/sm_cmp.sv
// Combinational sign-magnitude comparator: gt = (a > b), eq = (a == b).
module sm_cmp
   import sm_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         gt,
   output logic         eq
);

   localparam int SB = sm_sign_pos(W);
   localparam int MB = sm_mag_msb(W);

   logic [SM_MW-1:0] ma;
   logic [SM_MW-1:0] mb;

   assign ma = SM_MW'(a[MB:0]);
   assign mb = SM_MW'(b[MB:0]);

   assign gt = sm_gt(a[SB], ma, b[SB], mb);
   assign eq = sm_eq(a[SB], ma, b[SB], mb);

endmodule

// File: rtl/sm_stream_minmax.sv
// Framed sign-magnitude running max/min tracker with held result handshake.
// Optional frame counter output enabled by defining SM_FRAME_CNT_EN.
module sm_stream_minmax
   import sm_pkg::*;
#(
   parameter  int W       = 8,
   parameter  int MAX_LEN = 16,
   localparam int IW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
   localparam int CW      = $clog2(MAX_LEN + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_data,
   input  logic          in_last,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_max,
   output logic [IW-1:0] out_max_idx,
   output logic [W-1:0]  out_min,
   output logic [IW-1:0] out_min_idx,
   output logic [CW-1:0] out_count,
`ifdef SM_FRAME_CNT_EN
   output logic [15:0]   out_frame_id,
`endif
   output logic          out_ovf
);

   localparam logic [CW-1:0] LEN_M1 = CW'(MAX_LEN - 1);
   localparam logic [CW-1:0] ONE    = CW'(1);

   sm_state_t     state_q, state_d;
   logic [W-1:0]  max_q, max_d;
   logic [W-1:0]  min_q, min_d;
   logic [IW-1:0] max_idx_q, max_idx_d;
   logic [IW-1:0] min_idx_q, min_idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ovf_q, ovf_d;

   logic acc;
   logic max_gt, max_eq;
   logic min_gt, min_eq;
   logic min_lt;

   sm_cmp #(.W(W)) u_cmp_max (
      .a  (in_data),
      .b  (max_q),
      .gt (max_gt),
      .eq (max_eq)
   );

   sm_cmp #(.W(W)) u_cmp_min (
      .a  (in_data),
      .b  (min_q),
      .gt (min_gt),
      .eq (min_eq)
   );

   assign min_lt    = !min_gt && !min_eq;
   assign in_ready  = (state_q != HOLD);
   assign out_valid = (state_q == HOLD);
   assign acc       = in_valid && in_ready;

   always_comb begin
      state_d   = state_q;
      max_d     = max_q;
      min_d     = min_q;
      max_idx_d = max_idx_q;
      min_idx_d = min_idx_q;
      cnt_d     = cnt_q;
      ovf_d     = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (acc) begin
               max_d     = in_data;
               min_d     = in_data;
               max_idx_d = '0;
               min_idx_d = '0;
               cnt_d     = ONE;
               ovf_d     = 1'b0;
               if (in_last || MAX_LEN == 1) begin
                  state_d = HOLD;
                  ovf_d   = !in_last;
               end else begin
                  state_d = ACCUM;
               end
            end
         end
         ACCUM: begin
            if (acc) begin
               // Strict compares keep the first occurrence on ties.
               if (max_gt && !max_eq) begin
                  max_d     = in_data;
                  max_idx_d = cnt_q[IW-1:0];
               end
               if (min_lt) begin
                  min_d     = in_data;
                  min_idx_d = cnt_q[IW-1:0];
               end
               cnt_d = cnt_q + ONE;
               if (in_last || cnt_q == LEN_M1) begin
                  state_d = HOLD;
                  ovf_d   = !in_last;
               end
            end
         end
         HOLD: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         max_q     <= '0;
         min_q     <= '0;
         max_idx_q <= '0;
         min_idx_q <= '0;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         max_q     <= max_d;
         min_q     <= min_d;
         max_idx_q <= max_idx_d;
         min_idx_q <= min_idx_d;
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
      end
   end

   assign out_max     = max_q;
   assign out_min     = min_q;
   assign out_max_idx = max_idx_q;
   assign out_min_idx = min_idx_q;
   assign out_count   = cnt_q;
   assign out_ovf     = ovf_q;

`ifdef SM_FRAME_CNT_EN
   logic [15:0] fid_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                      fid_q <= '0;
      else if (out_valid && out_ready) fid_q <= fid_q + 16'd1;
   end

   assign out_frame_id = fid_q;
`endif

endmodule

// File: tb/tb_sm_stream_minmax.sv
// Directed self-checking bench for sm_stream_minmax (W=8, MAX_LEN=16).
module tb_sm_stream_minmax;

   localparam int W  = 8;
   localparam int ML = 16;
   localparam int IW = 4;
   localparam int CW = 5;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic          in_last;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_max;
   logic [IW-1:0] out_max_idx;
   logic [W-1:0]  out_min;
   logic [IW-1:0] out_min_idx;
   logic [CW-1:0] out_count;
   logic          out_ovf;
`ifdef SM_FRAME_CNT_EN
   logic [15:0]   out_frame_id;
`endif

   int checks = 0;
   int errors = 0;

   sm_stream_minmax #(.W(W), .MAX_LEN(ML)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_last     (in_last),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_max     (out_max),
      .out_max_idx (out_max_idx),
      .out_min     (out_min),
      .out_min_idx (out_min_idx),
      .out_count   (out_count),
`ifdef SM_FRAME_CNT_EN
      .out_frame_id(out_frame_id),
`endif
      .out_ovf     (out_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One beat, driven at negedge and consumed at the next posedge.
   task automatic send(input logic [7:0] d, input logic l);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic result(input string tag, input logic [7:0] mx,
                         input logic [3:0] mxi, input logic [7:0] mn,
                         input logic [3:0] mni, input logic [4:0] cnt,
                         input logic ovf);
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_max"}, 32'(out_max), 32'(mx));
      chk({tag, "_maxi"}, 32'(out_max_idx), 32'(mxi));
      chk({tag, "_min"}, 32'(out_min), 32'(mn));
      chk({tag, "_mini"}, 32'(out_min_idx), 32'(mni));
      chk({tag, "_cnt"}, 32'(out_count), 32'(cnt));
      chk({tag, "_ovf"}, 32'(out_ovf), 32'(ovf));
   endtask

   task automatic take(input string tag);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({tag, "_vdrop"}, 32'(out_valid), 32'd0);
      chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      #12;
      chk("rst_ready", 32'(in_ready), 32'd1);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_max", 32'(out_max), 32'd0);
      chk("rst_cnt", 32'(out_count), 32'd0);
      chk("rst_ovf", 32'(out_ovf), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic frame with idle gaps inside ACCUM.
      send(8'h05, 1'b0);
      send(8'h83, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("gap_valid", 32'(out_valid), 32'd0);
      chk("gap_ready", 32'(in_ready), 32'd1);
      send(8'h7F, 1'b0);
      send(8'hFF, 1'b1);
`ifdef SM_FRAME_CNT_EN
      chk("fid0", 32'(out_frame_id), 32'd0);
`endif
      result("basic", 8'h7F, 4'd2, 8'hFF, 4'd3, 5'd4, 1'b0);
      take("basic");

      // Signed zero ties keep the first occurrence.
      send(8'h80, 1'b0);
      send(8'h00, 1'b1);
`ifdef SM_FRAME_CNT_EN
      chk("fid1", 32'(out_frame_id), 32'd1);
`endif
      result("zero", 8'h80, 4'd0, 8'h80, 4'd0, 5'd2, 1'b0);
      take("zero");

      send(8'h01, 1'b0);
      send(8'h81, 1'b0);
      send(8'h00, 1'b1);
`ifdef SM_FRAME_CNT_EN
      chk("fid2", 32'(out_frame_id), 32'd2);
`endif
      result("pm1", 8'h01, 4'd0, 8'h81, 4'd1, 5'd3, 1'b0);
      take("pm1");

      // Overflow: 16 beats without in_last.
      for (int i = 0; i < ML; i++) send(8'h10, 1'b0);
      result("ovf", 8'h10, 4'd0, 8'h10, 4'd0, 5'd16, 1'b1);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'h20;
      in_last  = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("ovf_hold_rdy", 32'(in_ready), 32'd0);
         chk("ovf_hold_cnt", 32'(out_count), 32'd16);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      take("ovf");
      send(8'h20, 1'b1);
      result("post_ovf", 8'h20, 4'd0, 8'h20, 4'd0, 5'd1, 1'b0);
      take("post_ovf");

      // Backpressure: result held stable while out_ready is low.
      send(8'h11, 1'b0);
      send(8'h22, 1'b1);
      result("bp", 8'h22, 4'd1, 8'h11, 4'd0, 5'd2, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_ready", 32'(in_ready), 32'd0);
         chk("bp_max", 32'(out_max), 32'h22);
         chk("bp_min", 32'(out_min), 32'h11);
         chk("bp_cnt", 32'(out_count), 32'd2);
      end
      take("bp");

      // Asynchronous reset in the middle of a frame.
      send(8'h01, 1'b0);
      send(8'h02, 1'b0);
      send(8'h03, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ready", 32'(in_ready), 32'd1);
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_max", 32'(out_max), 32'd0);
      chk("mid_rst_min", 32'(out_min), 32'd0);
      chk("mid_rst_cnt", 32'(out_count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      send(8'h42, 1'b1);
      result("single", 8'h42, 4'd0, 8'h42, 4'd0, 5'd1, 1'b0);
      take("single");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
